// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) memory arbiter with bus lock, HOLD timeout and registered read data.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise port 0 always wins ties.
module mem_arbiter #(
   parameter int M = 16,
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req,
   input  logic [1:0]     lock,
   input  logic [1:0]     we,
   input  logic [2*N-1:0] addr,
   input  logic [2*M-1:0] wdata,
   output logic [1:0]     gnt,
   output logic [1:0]     ack,
   output logic [M-1:0]   rdata,
   output logic [N-1:0]   memAddr,
   input  logic [M-1:0]   memRead,
   output logic [M-1:0]   memWrite,
   output logic           memWE
);

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, HOLD0, HOLD1} state_t;

   state_t     state, stateNext;
   logic [3:0] holdCnt;
   logic       holdTimeout;
   logic       tieWinner;

`ifdef ARB_ROUND_ROBIN_EN
   logic lastServed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  lastServed <= 1'b1;
      else if (stateNext == ACC0) lastServed <= 1'b0;
      else if (stateNext == ACC1) lastServed <= 1'b1;
   end

   assign tieWinner = ~lastServed;
`else
   assign tieWinner = 1'b0;
`endif

   // holdCnt counts completed HOLD cycles; leave on the 15th
   assign holdTimeout = (holdCnt == 4'd14);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         holdCnt <= '0;
         ack     <= '0;
         rdata   <= '0;
      end else begin
         state <= stateNext;
         ack   <= '0;
         if (state == HOLD0 || state == HOLD1) holdCnt <= holdCnt + 4'd1;
         else                                  holdCnt <= '0;
         if (state == ACC0) begin
            ack[0] <= 1'b1;
            if (!we[0]) rdata <= memRead;
         end else if (state == ACC1) begin
            ack[1] <= 1'b1;
            if (!we[1]) rdata <= memRead;
         end
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (req == 2'b11)  stateNext = tieWinner ? ACC1 : ACC0;
            else if (req[0])   stateNext = ACC0;
            else if (req[1])   stateNext = ACC1;
         end
         ACC0:  stateNext = lock[0] ? HOLD0 : IDLE;
         ACC1:  stateNext = lock[1] ? HOLD1 : IDLE;
         HOLD0: begin
            if (req[0])                       stateNext = ACC0;
            else if (!lock[0] || holdTimeout) stateNext = IDLE;
         end
         HOLD1: begin
            if (req[1])                       stateNext = ACC1;
            else if (!lock[1] || holdTimeout) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      memAddr  = '0;
      memWrite = '0;
      memWE    = 1'b0;
      gnt[0]   = (state == ACC0) || (state == HOLD0);
      gnt[1]   = (state == ACC1) || (state == HOLD1);
      if (state == ACC0) begin
         memAddr  = addr[0 +: N];
         memWrite = wdata[0 +: M];
         memWE    = we[0];
      end else if (state == ACC1) begin
         memAddr  = addr[N +: N];
         memWrite = wdata[M +: M];
         memWE    = we[1];
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, write, tie-break, lock/HOLD, timeout and reset abort.
module tb_mem_arbiter;

   localparam int M = 16;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     req, lock, we;
   logic [2*N-1:0] addr;
   logic [2*M-1:0] wdata;
   logic [1:0]     gnt, ack;
   logic [M-1:0]   rdata, memRead, memWrite;
   logic [N-1:0]   memAddr;
   logic           memWE;

   int total = 0;
   int bad   = 0;
   logic [1:0] tieSeq [4];

   mem_arbiter #(.M(M), .N(N)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
      .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .memAddr(memAddr),
      .memRead(memRead), .memWrite(memWrite), .memWE(memWE)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      tieSeq[0] = 2'b01; tieSeq[1] = 2'b10; tieSeq[2] = 2'b01; tieSeq[3] = 2'b10;
`else
      tieSeq[0] = 2'b01; tieSeq[1] = 2'b01; tieSeq[2] = 2'b01; tieSeq[3] = 2'b01;
`endif
      rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0; memRead = '0;
      tick(); tick();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_ack", ack, 2'b00);
      chk("rst_rdata", rdata, 16'h0);
      chk("rst_memWE", memWE, 1'b0);
      rst = 1'b1;
      tick();

      // single read on port 0
      addr[31:0] = 32'h100; memRead = 16'hBEEF; req = 2'b01;
      tick();
      chk("rd_gnt", gnt, 2'b01);
      chk("rd_memAddr", memAddr, 32'h100);
      chk("rd_memWE", memWE, 1'b0);
      chk("rd_ack_early", ack, 2'b00);
      tick();
      chk("rd_ack", ack, 2'b01);
      chk("rd_rdata", rdata, 16'hBEEF);
      chk("rd_gnt_idle", gnt, 2'b00);
      chk("rd_memAddr_idle", memAddr, 32'h0);
      req = 2'b00;
      tick();
      chk("rd_ack_pulse", ack, 2'b00);

      // write on port 1
      addr[63:32] = 32'hD000; wdata[31:16] = 16'h1234; we = 2'b10; req = 2'b10; memRead = 16'h5555;
      tick();
      chk("wr_gnt", gnt, 2'b10);
      chk("wr_memWE", memWE, 1'b1);
      chk("wr_memAddr", memAddr, 32'hD000);
      chk("wr_memWrite", memWrite, 16'h1234);
      tick();
      chk("wr_ack", ack, 2'b10);
      chk("wr_memWE_off", memWE, 1'b0);
      chk("wr_rdata_kept", rdata, 16'hBEEF);
      req = 2'b00; we = 2'b00;
      tick();

      // simultaneous requests
      memRead = 16'h1111; req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("tie_gnt%0d", i), gnt, tieSeq[i]);
         tick();
         chk($sformatf("tie_ack%0d", i), ack, tieSeq[i]);
      end
      req = 2'b10;
      tick();
      chk("tie_gnt_p1", gnt, 2'b10);
      tick();
      chk("tie_ack_p1", ack, 2'b10);
      chk("tie_rdata", rdata, 16'h1111);
      req = 2'b00;
      tick();

      // lock: port 0 keeps the bus, port 1 waits
      addr[31:0] = 32'h200; memRead = 16'h2222; req = 2'b01; lock = 2'b01;
      tick();
      chk("lk_gnt_acc", gnt, 2'b01);
      tick();
      chk("lk_ack", ack, 2'b01);
      chk("lk_gnt_hold", gnt, 2'b01);
      chk("lk_memWE_hold", memWE, 1'b0);
      chk("lk_memAddr_hold", memAddr, 32'h0);
      chk("lk_rdata", rdata, 16'h2222);
      req = 2'b10;
      tick();
      chk("lk_hold1", gnt, 2'b01);
      tick();
      chk("lk_hold2", gnt, 2'b01);
      addr[31:0] = 32'h300; memRead = 16'h3333; req = 2'b11;
      tick();
      chk("lk_reacc_gnt", gnt, 2'b01);
      chk("lk_reacc_addr", memAddr, 32'h300);
      lock = 2'b00;
      tick();
      chk("lk_ack2", ack, 2'b01);
      chk("lk_idle", gnt, 2'b00);
      chk("lk_rdata2", rdata, 16'h3333);
      req = 2'b10;
      tick();
      chk("lk_p1_gnt", gnt, 2'b10);
      tick();
      chk("lk_p1_ack", ack, 2'b10);
      req = 2'b00;
      tick();

      // HOLD timeout with port 1 pending
      addr[31:0] = 32'h400; req = 2'b01; lock = 2'b01;
      tick();
      chk("to_acc", gnt, 2'b01);
      tick();
      chk("to_ack", ack, 2'b01);
      req = 2'b10;
      for (int i = 0; i < 14; i++) begin
         tick();
         chk($sformatf("to_hold%0d", i + 1), gnt, 2'b01);
      end
      tick();
      chk("to_idle", gnt, 2'b00);
      tick();
      chk("to_p1_gnt", gnt, 2'b10);
      lock = 2'b00;
      tick();
      chk("to_p1_ack", ack, 2'b10);
      req = 2'b00;
      tick();

      // reset during ACC1 write
      memRead = 16'h7777; addr[63:32] = 32'hD000; wdata[31:16] = 16'hAAAA; we = 2'b10; req = 2'b10;
      tick();
      chk("ra_memWE_on", memWE, 1'b1);
      chk("ra_gnt_on", gnt, 2'b10);
      rst = 1'b0;
      #1;
      chk("ra_memWE", memWE, 1'b0);
      chk("ra_gnt", gnt, 2'b00);
      chk("ra_rdata", rdata, 16'h0);
      tick();
      chk("ra_no_ack", ack, 2'b00);
      req = 2'b00; we = 2'b00; rst = 1'b1;
      tick();
      chk("ra_idle", gnt, 2'b00);
      req = 2'b01;
      tick();
      chk("ra_resume_gnt", gnt, 2'b01);
      tick();
      chk("ra_resume_ack", ack, 2'b01);
      chk("ra_resume_rdata", rdata, 16'h7777);
      req = 2'b00;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter M, default 16, data bus width.
REQ-002 Parameter N, default 32, address bus width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-port access request; bit k = port k (0 = CPU, 1 = DMA).
REQ-006 lock  input  2  per-port bus-lock hint, sampled during that port's access.
REQ-007 we  input  2  per-port write enable for the requested access.
REQ-008 addr  input  2N  per-port address; port k at bits [k*N +: N].
REQ-009 wdata  input  2M  per-port write data; port k at bits [k*M +: M].
REQ-010 gnt  output  2  one-hot; bit k high while port k owns the bus (ACC_k or HOLD_k).
REQ-011 ack  output  2  one-cycle completion pulse per port.
REQ-012 rdata  output  M  registered read data, shared by both ports.
REQ-013 memAddr  output  N  memory address.
REQ-014 memRead  input  M  memory read data, combinational, valid in the same cycle.
REQ-015 memWrite  output  M  memory write data.
REQ-016 memWE  output  1  memory write enable.

Function
REQ-017 States SHALL be IDLE, ACC0, ACC1, HOLD0 and HOLD1.
REQ-018 Requester handshake: hold req[k], we[k], addr and wdata stable until ack[k]; no other signalling is required.
REQ-019 IDLE: if exactly one req bit is set, go to ACC of that port on the next edge; if none is set, stay in IDLE.
REQ-020 IDLE with both req bits set: the tie SHALL be resolved by the priority rule in REQ-033/REQ-034.
REQ-021 ACC_k: memAddr = addr_k, memWrite = wdata_k, memWE = we[k]; these SHALL be combinational from state and port k inputs.
REQ-022 ACC_k lasts exactly one cycle; at its closing edge rdata <= memRead (reads only; writes leave rdata unchanged) and ack[k] <= 1 for one cycle.
REQ-023 Exit from ACC_k: go to HOLD_k if lock[k] was high during ACC_k, otherwise go to IDLE.
REQ-024 HOLD_k: req[k] high -> ACC_k; else lock[k] low -> IDLE; else stay.
REQ-025 HOLD_k: req of the other port SHALL be ignored.
REQ-026 HOLD timeout: a 4-bit counter clears on entry to HOLD_k and increments each cycle spent in HOLD_k; at count 15 the state SHALL go to IDLE regardless of lock.
REQ-027 A req[k] still high during the ack[k] cycle SHALL be treated as a new request. Minimum spacing is 2 cycles per access from IDLE and 2 cycles via HOLD.
REQ-028 In IDLE and HOLD, memAddr, memWrite and memWE SHALL be 0.
REQ-029 Request-to-ack latency SHALL be 2 cycles when the bus is free.

Reset
REQ-030 rst low SHALL immediately force state IDLE, gnt = 0, ack = 0, rdata = 0, HOLD counter = 0 and the priority pointer to "port 1 last served".
REQ-031 Reset asserted mid-access SHALL abort the access with no ack and drop memWE in the same cycle, since outputs decode from state.
REQ-032 After rst deasserts, arbitration SHALL resume on the first rising edge.

Configuration
REQ-033 With ARB_ROUND_ROBIN_EN defined: a 1-bit last-served pointer updates on every ACC_k entry; on a tie the port not last served SHALL win.
REQ-034 Without ARB_ROUND_ROBIN_EN: port 0 SHALL always win ties, and no pointer register SHALL be built.

Verification
REQ-035 Single read: req = 01, addr0 = 0x100, memRead = 0xBEEF -> memAddr = 0x100 in cycle 1, ack = 01 and rdata = 0xBEEF in cycle 2.
REQ-036 Simultaneous request: req = 11 from IDLE after reset -> with ARB_ROUND_ROBIN_EN, grant sequence 0,1,0,1; without it, port 0 always wins until req0 drops.
REQ-037 Write: req = 10, we = 10, addr1 = 0xD000, wdata1 = 0x1234 -> memWE = 1 for exactly one cycle with those values, and rdata unchanged.
REQ-038 Lock: port 0 access with lock0 = 1, then req = 11 -> port 1 waits until lock0 drops; a second port 0 access proceeds from HOLD0 without going through IDLE.
REQ-039 Timeout: lock0 held high with req0 low -> state returns to IDLE 15 cycles after HOLD0 entry, and a pending port 1 request is granted next.
REQ-040 Reset in ACC1 -> memWE = 0 immediately, no ack pulse, gnt = 00, rdata = 0.
